// File: rtl/adc_multich_reader.sv
`default_nettype none
// ============================================================================
// Module   : adc_multich_reader
// Purpose  : Serial multi-channel ADC frame reader. It synchronises
//            drdy/dclk/din, shifts in NUM_CH x DATA_W bits per frame, and
//            presents all channels in parallel with a tick, a wrapping
//            sample counter and a selectable {counter, channel} word. It
//            also flags aborted frames.
// Options  : `define ADC_MULTICH_TIMEOUT_EN adds a dclk-inactivity timeout
//            abort. When it is not defined, timeout_o is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module adc_multich_reader #(
   parameter int NUM_CH      = 2,
   parameter int DATA_W      = 24,
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       drdy_i,
   input  logic                       dclk_i,
   input  logic                       din_i,
   input  logic                       clr_err_i,
   input  logic [2:0]                 sel_i,
   output logic [NUM_CH*DATA_W-1:0]   ch_o,
   output logic                       tick_o,
   output logic [CNT_W-1:0]           sample_cnt_o,
   output logic                       frame_err_o,
   output logic                       timeout_o,
   output logic [CNT_W+DATA_W-1:0]    oreg_o
);

   localparam int TOTAL  = NUM_CH * DATA_W;
   localparam int BCNT_W = $clog2(TOTAL + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state, next_state;

   logic [SYNC_STAGES-1:0] drdy_sync, dclk_sync, din_sync;
   logic                   drdy_s, dclk_s, din_s;
   logic                   drdy_d, dclk_d;
   logic                   drdy_rise, drdy_fall, dclk_rise;

   logic [TOTAL-1:0]       shift_reg;
   logic [TOTAL-1:0]       next_shift;
   logic [TOTAL-1:0]       ordered;
   logic [BCNT_W-1:0]      bit_cnt;

   logic                   start, shift_en, last_bit, abort, tmo_abort, tmo_hit;
   logic [DATA_W-1:0]      sel_data;

   // Synchroniser chains for the asynchronous ADC inputs, plus the edge-detect flop
   always_ff @(posedge clk) begin
      if (reset) begin
         drdy_sync <= '0;
         dclk_sync <= '0;
         din_sync  <= '0;
         drdy_d    <= 1'b0;
         dclk_d    <= 1'b0;
      end else begin
         drdy_sync <= {drdy_sync[SYNC_STAGES-2:0], drdy_i};
         dclk_sync <= {dclk_sync[SYNC_STAGES-2:0], dclk_i};
         din_sync  <= {din_sync[SYNC_STAGES-2:0], din_i};
         drdy_d    <= drdy_s;
         dclk_d    <= dclk_s;
      end
   end

   // din shares the dclk chain depth, so it is aligned with the detected edge
   assign drdy_s    = drdy_sync[SYNC_STAGES-1];
   assign dclk_s    = dclk_sync[SYNC_STAGES-1];
   assign din_s     = din_sync[SYNC_STAGES-1];
   assign drdy_rise =  drdy_s & ~drdy_d;
   assign drdy_fall = ~drdy_s &  drdy_d;
   assign dclk_rise =  dclk_s & ~dclk_d;

   // The shift register holds channel 0 in its top slot once a frame is complete
   assign next_shift = {shift_reg[TOTAL-2:0], din_s};

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch_order
      assign ordered[k*DATA_W +: DATA_W] = next_shift[(NUM_CH-1-k)*DATA_W +: DATA_W];
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state and control decode; an early drdy rise takes priority over a dclk edge
   always_comb begin
      next_state = state;
      start      = 1'b0;
      shift_en   = 1'b0;
      last_bit   = 1'b0;
      abort      = 1'b0;
      tmo_abort  = 1'b0;
      case (state)
         IDLE: begin
            if (drdy_s) next_state = ARMED;
         end
         ARMED: begin
            if (drdy_fall) begin
               next_state = SHIFT;
               start      = 1'b1;
            end
         end
         SHIFT: begin
            if (drdy_rise) begin
               abort      = 1'b1;
               next_state = IDLE;
            end else if (dclk_rise) begin
               shift_en = 1'b1;
               if (bit_cnt == BCNT_W'(TOTAL - 1)) begin
                  last_bit   = 1'b1;
                  next_state = DONE;
               end
            end else if (tmo_hit) begin
               abort      = 1'b1;
               tmo_abort  = 1'b1;
               next_state = IDLE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Frame datapath: outputs are loaded on the final edge so they are valid during DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_reg    <= '0;
         bit_cnt      <= '0;
         ch_o         <= '0;
         sample_cnt_o <= '0;
      end else begin
         if (start) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
         end else if (shift_en) begin
            shift_reg <= next_shift;
            bit_cnt   <= bit_cnt + 1'b1;
         end
         if (last_bit) begin
            ch_o         <= ordered;
            sample_cnt_o <= sample_cnt_o + 1'b1;
         end
      end
   end

   assign tick_o = (state == DONE);

   // Sticky frame error; a new abort outranks a simultaneous clear
   always_ff @(posedge clk) begin
      if (reset) frame_err_o <= 1'b0;
      else       frame_err_o <= abort | (frame_err_o & ~clr_err_i);
   end

`ifdef ADC_MULTICH_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] tmo_cnt;
   logic             timeout_flag;

   // Inactivity counter: restarts on every dclk edge and whenever SHIFT is (re)entered
   always_ff @(posedge clk) begin
      if (reset || start || dclk_rise || state != SHIFT) tmo_cnt <= '0;
      else                                               tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

   // Sticky timeout cause flag, same set-wins rule as frame_err_o
   always_ff @(posedge clk) begin
      if (reset) timeout_flag <= 1'b0;
      else       timeout_flag <= tmo_abort | (timeout_flag & ~clr_err_i);
   end

   assign timeout_o = timeout_flag;
`else
   // Without the timeout option the only abort cause is an early drdy rise
   logic unused_tmo;
   assign tmo_hit    = 1'b0;
   assign timeout_o  = 1'b0;
   assign unused_tmo = tmo_abort ^ (TIMEOUT_CYC != 0);
`endif

   // Register-interface word; out-of-range selects read back a zero data field
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (sel_i == 3'(k)) sel_data = ch_o[k*DATA_W +: DATA_W];
      end
   end

   assign oreg_o = {sample_cnt_o, sel_data};

endmodule
`default_nettype wire

// File: tb/tb_adc_multich_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_multich_reader
// Purpose  : Directed self-checking bench for adc_multich_reader
//            (NUM_CH=2, DATA_W=24, CNT_W=8, TIMEOUT_CYC=64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_multich_reader;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          drdy = 1'b1;
   logic          dclk = 1'b0;
   logic          din = 1'b0;
   logic          clr_err = 1'b0;
   logic [2:0]    sel = 3'd0;
   logic [47:0]   ch;
   logic          tick;
   logic [7:0]    cnt;
   logic          ferr;
   logic          tmo;
   logic [31:0]   oreg;

   int checks = 0;
   int errors = 0;
   int ticks  = 0;
   int dbl    = 0;
   logic prev_tick = 1'b0;

   adc_multich_reader #(
      .NUM_CH(2), .DATA_W(24), .CNT_W(8), .SYNC_STAGES(2), .TIMEOUT_CYC(64)
   ) dut (
      .clk(clk), .reset(reset), .drdy_i(drdy), .dclk_i(dclk), .din_i(din),
      .clr_err_i(clr_err), .sel_i(sel), .ch_o(ch), .tick_o(tick),
      .sample_cnt_o(cnt), .frame_err_o(ferr), .timeout_o(tmo), .oreg_o(oreg)
   );

   always #5 clk = ~clk;

   // Tick monitor, sampled just after each active edge
   always @(posedge clk) begin
      #1;
      if (tick) ticks++;
      if (tick && prev_tick) dbl++;
      prev_tick = tick;
   end

   task automatic clk_wait(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      din  = b;
      dclk = 1'b0;
      clk_wait(2);
      dclk = 1'b1;
      clk_wait(2);
   endtask

   task automatic send_bits(input logic [47:0] v, input int first, input int last);
      for (int i = first; i <= last; i++) send_bit(v[47-i]);
   endtask

   task automatic frame(input logic [23:0] c0, input logic [23:0] c1);
      drdy = 1'b1;
      clk_wait(4);
      drdy = 1'b0;
      clk_wait(4);
      send_bits({c0, c1}, 0, 47);
      clk_wait(4);
      drdy = 1'b1;
      clk_wait(2);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clk_wait(4);
      checks++; if (ch !== 48'h0)  begin errors++; $display("FAIL reset_ch got %h want 0", ch); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick); end
      checks++; if (cnt !== 8'h0)  begin errors++; $display("FAIL reset_cnt got %h want 0", cnt); end
      checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", ferr); end
      checks++; if (tmo !== 1'b0)  begin errors++; $display("FAIL reset_tmo got %b want 0", tmo); end
      reset = 1'b0;
      clk_wait(2);
   endtask

   task automatic test_nominal();
      int t0;
      t0 = ticks;
      frame(24'h7FFFFF, 24'h800001);
      checks++; if (ticks - t0 !== 1) begin errors++; $display("FAIL nom_ticks got %0d want 1", ticks - t0); end
      checks++; if (ch[23:0] !== 24'h7FFFFF) begin errors++; $display("FAIL nom_ch0 got %h want 7fffff", ch[23:0]); end
      checks++; if (ch[47:24] !== 24'h800001) begin errors++; $display("FAIL nom_ch1 got %h want 800001", ch[47:24]); end
      checks++; if (cnt !== 8'd1) begin errors++; $display("FAIL nom_cnt got %h want 01", cnt); end
      sel = 3'd1; clk_wait(1);
      checks++; if (oreg !== 32'h01800001) begin errors++; $display("FAIL oreg_sel1 got %h want 01800001", oreg); end
      sel = 3'd0; clk_wait(1);
      checks++; if (oreg !== 32'h017FFFFF) begin errors++; $display("FAIL oreg_sel0 got %h want 017fffff", oreg); end
      sel = 3'd5; clk_wait(1);
      checks++; if (oreg !== 32'h01000000) begin errors++; $display("FAIL oreg_sel5 got %h want 01000000", oreg); end
      sel = 3'd2; clk_wait(1);
      checks++; if (oreg !== 32'h01000000) begin errors++; $display("FAIL oreg_sel2 got %h want 01000000", oreg); end
      sel = 3'd0;
   endtask

   task automatic test_early_drdy();
      int t0;
      t0 = ticks;
      drdy = 1'b1; clk_wait(4);
      drdy = 1'b0; clk_wait(4);
      send_bits(48'hABCDEF_123456, 0, 29);
      drdy = 1'b1;
      clk_wait(8);
      checks++; if (ticks - t0 !== 0) begin errors++; $display("FAIL early_tick got %0d want 0", ticks - t0); end
      checks++; if (ferr !== 1'b1) begin errors++; $display("FAIL early_ferr got %b want 1", ferr); end
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL early_tmo got %b want 0", tmo); end
      checks++; if (ch !== 48'h800001_7FFFFF) begin errors++; $display("FAIL early_ch got %h want 8000017fffff", ch); end
      checks++; if (cnt !== 8'd1) begin errors++; $display("FAIL early_cnt got %h want 01", cnt); end
      frame(24'h123456, 24'hABCDEF);
      checks++; if (ticks - t0 !== 1) begin errors++; $display("FAIL after_tick got %0d want 1", ticks - t0); end
      checks++; if (ch !== 48'hABCDEF_123456) begin errors++; $display("FAIL after_ch got %h want abcdef123456", ch); end
      checks++; if (cnt !== 8'd2) begin errors++; $display("FAIL after_cnt got %h want 02", cnt); end
      checks++; if (ferr !== 1'b1) begin errors++; $display("FAIL sticky_ferr got %b want 1", ferr); end
      clr_err = 1'b1; clk_wait(1);
      clr_err = 1'b0; clk_wait(1);
      checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL clr_ferr got %b want 0", ferr); end
   endtask

   task automatic test_counter_wrap();
      int t0;
      t0 = ticks;
      for (int i = 0; i < 254; i++) frame(24'(i), ~24'(i));
      checks++; if (cnt !== 8'h00) begin errors++; $display("FAIL wrap_zero got %h want 00", cnt); end
      for (int i = 254; i < 256; i++) frame(24'(i), ~24'(i));
      checks++; if (ticks - t0 !== 256) begin errors++; $display("FAIL wrap_ticks got %0d want 256", ticks - t0); end
      checks++; if (cnt !== 8'h02) begin errors++; $display("FAIL wrap_cnt got %h want 02", cnt); end
      checks++; if (ch !== 48'hFFFF00_0000FF) begin errors++; $display("FAIL wrap_ch got %h want ffff000000ff", ch); end
   endtask

   task automatic test_simultaneous();
      int t0;
      t0 = ticks;
      drdy = 1'b1; clk_wait(4);
      drdy = 1'b0; clk_wait(4);
      send_bits(48'h555555_AAAAAA, 0, 4);
      // drdy rise is seen two edges later; clear lands on the abort edge
      drdy = 1'b1;
      clk_wait(2);
      clr_err = 1'b1; clk_wait(1);
      clr_err = 1'b0; clk_wait(2);
      checks++; if (ferr !== 1'b1) begin errors++; $display("FAIL simul_ferr got %b want 1", ferr); end
      checks++; if (ticks - t0 !== 0) begin errors++; $display("FAIL simul_tick got %0d want 0", ticks - t0); end
      clr_err = 1'b1; clk_wait(1);
      clr_err = 1'b0; clk_wait(1);
      send_bits(48'h123456_654321, 0, 47);
      clk_wait(4);
      checks++; if (ticks - t0 !== 0) begin errors++; $display("FAIL drdy_high_tick got %0d want 0", ticks - t0); end
      checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL drdy_high_ferr got %b want 0", ferr); end
      checks++; if (cnt !== 8'h02) begin errors++; $display("FAIL drdy_high_cnt got %h want 02", cnt); end
   endtask

   task automatic test_reset_mid_frame();
      int t0;
      drdy = 1'b1; clk_wait(4);
      drdy = 1'b0; clk_wait(4);
      send_bits(48'hFFFFFF_FFFFFF, 0, 19);
      reset = 1'b1; clk_wait(3);
      reset = 1'b0; clk_wait(2);
      t0 = ticks;
      send_bits(48'hFFFFFF_FFFFFF, 0, 47);
      clk_wait(4);
      checks++; if (ticks - t0 !== 0) begin errors++; $display("FAIL rmf_tick got %0d want 0", ticks - t0); end
      checks++; if (ch !== 48'h0) begin errors++; $display("FAIL rmf_ch got %h want 0", ch); end
      checks++; if (cnt !== 8'h0) begin errors++; $display("FAIL rmf_cnt got %h want 0", cnt); end
      checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL rmf_ferr got %b want 0", ferr); end
      checks++; if (oreg !== 32'h0) begin errors++; $display("FAIL rmf_oreg got %h want 0", oreg); end
      frame(24'h000123, 24'hFFFFFF);
      checks++; if (ticks - t0 !== 1) begin errors++; $display("FAIL rmf_next_tick got %0d want 1", ticks - t0); end
      checks++; if (ch !== 48'hFFFFFF_000123) begin errors++; $display("FAIL rmf_next_ch got %h want ffffff000123", ch); end
      checks++; if (cnt !== 8'd1) begin errors++; $display("FAIL rmf_next_cnt got %h want 01", cnt); end
   endtask

   task automatic test_timeout();
      int t0;
      t0 = ticks;
      drdy = 1'b1; clk_wait(4);
      drdy = 1'b0; clk_wait(4);
      send_bits(48'h0F0F0F_C3C3C3, 0, 9);
      clk_wait(100);
`ifdef ADC_MULTICH_TIMEOUT_EN
      checks++; if (ferr !== 1'b1) begin errors++; $display("FAIL tmo_ferr got %b want 1", ferr); end
      checks++; if (tmo !== 1'b1) begin errors++; $display("FAIL tmo_flag got %b want 1", tmo); end
      checks++; if (ticks - t0 !== 0) begin errors++; $display("FAIL tmo_tick got %0d want 0", ticks - t0); end
      drdy = 1'b1; clk_wait(4);
`else
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL notmo_flag got %b want 0", tmo); end
      checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL notmo_ferr got %b want 0", ferr); end
      // still in SHIFT: the remaining bits complete the same frame
      send_bits(48'h0F0F0F_C3C3C3, 10, 47);
      clk_wait(4);
      checks++; if (ticks - t0 !== 1) begin errors++; $display("FAIL notmo_tick got %0d want 1", ticks - t0); end
      checks++; if (ch !== 48'hC3C3C3_0F0F0F) begin errors++; $display("FAIL notmo_ch got %h want c3c3c30f0f0f", ch); end
      checks++; if (cnt !== 8'd2) begin errors++; $display("FAIL notmo_cnt got %h want 02", cnt); end
      drdy = 1'b1; clk_wait(4);
`endif
   endtask

   task automatic test_tick_pulse();
      checks++; if (dbl !== 0) begin errors++; $display("FAIL tick_width got %0d double ticks want 0", dbl); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_early_drdy();
      test_counter_wrap();
      test_simultaneous();
      test_reset_mid_frame();
      test_timeout();
      test_tick_pulse();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
